recip_share_ctrl: RTL and testbench
===================================

# recip_share_ctrl

Round-robin scheduler that shares one iterative FP16 reciprocal unit among N vector lanes. It accepts one divisor at a time from the requesting lanes and drives the unit's `divisor`/`divisor_valid` pulse. It then waits for `complete` and returns the result to the lane that issued the divisor. A watchdog bounds the wait so a hung unit cannot stall the lanes.

## Interface
- N_REQ, 4, number of requesting lanes (2..8)
- W, 16, operand/result width (FP16)
- TIMEOUT, 64, max cycles waited for `complete` before an error response
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- req_valid  in  N_REQ  per-lane request
- req_data  in  N_REQ*W  per-lane divisor; lane i at [i*W +: W]
- req_ready  out  N_REQ  per-lane accept, one-hot or zero
- resp_valid  out  N_REQ  per-lane response, one-hot or zero
- resp_data  out  W  reciprocal result, shared by all lanes
- resp_err  out  1  response is a timeout error; resp_data = 16'h7E00 (qNaN)
- resp_ready  in  N_REQ  per-lane response accept
- divisor  out  W  to reciprocal unit
- divisor_valid  out  1  one-cycle start pulse to the unit
- result  in  W  from the unit
- complete  in  1  one-cycle done pulse from the unit

## Operation
- FSM states:
  - IDLE: grant = first lane with req_valid, searching from rr_ptr upward with wrap. req_ready[grant]=1 combinationally. On acceptance: latch the lane index in `owner`, latch req_data into `divisor`, go to ISSUE. If no request, stay in IDLE.
  - ISSUE: divisor_valid=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
  - WAIT: the wait counter increments each cycle.
    - On complete: latch result into resp_data, resp_err=0, go to RESP.
    - Else, when the counter reaches TIMEOUT-1: resp_data=16'h7E00, resp_err=1, go to RESP.
    - If complete and the timeout occur in the same cycle, complete wins.
  - RESP: resp_valid[owner]=1, with resp_data and resp_err held stable. When resp_ready[owner] is high: rr_ptr = (owner+1) mod N_REQ, go to IDLE.
- req_ready is zero in every state except IDLE, so at most one operation is in flight.
- complete outside WAIT, including complete arriving late after a timeout, is ignored.
- `divisor` holds its value after ISSUE until the next acceptance.
- Fairness: after lane i is served, lane i has the lowest priority at the next arbitration. With all lanes requesting continuously, the service order is 0,1,2,3,0,...
- Reset values: state=IDLE, rr_ptr=0, owner=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, divisor=0, divisor_valid=0, counter=0.
- Reset mid-operation: everything returns to its reset value next cycle. No response is produced for the aborted request. The reciprocal unit shares rst, so it is reset in the same cycle.

## Timing
- Request accepted in cycle T (req_valid & req_ready high at the T edge); divisor_valid is high in T+1.
- If complete is high in cycle C, resp_valid rises in C+1. End-to-end latency is (C−T)+1 cycles.
- Timeout: with divisor_valid at T+1 and no complete, resp_valid with resp_err=1 rises in T+2+TIMEOUT.
- resp_valid is held until the cycle resp_ready[owner] is high. The earliest next acceptance is the cycle after the handshake.
- Back-to-back throughput is one operation per (unit latency + 3) cycles, with zero response backpressure.
- The counter is $clog2(TIMEOUT) bits wide and does not wrap within one wait.

## Structure
- Shared package `vp_fp16_pkg`:
  - FP16_QNAN = 16'h7E00
  - ctrl state enum: IDLE, ISSUE, WAIT, RESP
  - lane index typedef
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
  - Reused later by other shared units (divide, sqrt).
- Top level holds the FSM, owner/divisor/result registers and the watchdog counter.

## Test plan
- Single request: lane 2, req_data=16'h4000 (2.0); stub unit returns 16'h3800 after 12 cycles. Required: divisor_valid exactly once in T+1; resp_valid[2] with 16'h3800 and resp_err=0 one cycle after complete; no other resp_valid bit set.
- All four lanes request continuously from reset. Required: grants in order 0,1,2,3,0; each divisor matches the granting lane's data; req_ready never has more than one bit high.
- Backpressure: hold resp_ready[1]=0 for 10 cycles. Required: resp_valid[1], resp_data and resp_err stay stable; req_ready stays 0; the next grant is in the cycle after the handshake.
- Timeout: the stub never asserts complete, TIMEOUT=64. Required: resp_err=1 and resp_data=16'h7E00 at T+66. A late complete afterwards is ignored and the next request proceeds normally.
- Simultaneous events: complete coincides with the timeout cycle, giving resp_err=0 and the unit's result. A stray complete in IDLE causes no response.
- Reset mid-operation: assert rst during WAIT. Required: next cycle all outputs are at reset values and rr_ptr=0; no response for the aborted lane; a fresh request afterwards is granted lane 0 first.

Source files
------------

// File: rtl/vp_fp16_pkg.sv
// rtl/vp_fp16_pkg.sv - shared FP16 vector-pipe types and constants
package vp_fp16_pkg;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    // Wide enough for the largest supported lane count (8)
    localparam int LANE_IDX_W = 3;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter
    import vp_fp16_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  lane_idx_t    ptr,
    output logic [N-1:0] grant,
    output lane_idx_t    grant_idx
);

    always_comb begin : pick
        int   lane;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        lane      = 0;
        for (int i = 0; i < N; i++) begin
            lane = (int'(ptr) + i) % N;
            for (int j = 0; j < N; j++) begin
                if (!found && (j == lane) && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = lane_idx_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/recip_share_ctrl.sv
// rtl/recip_share_ctrl.sv - shares one iterative FP16 reciprocal unit among N lanes
module recip_share_ctrl
    import vp_fp16_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_data,
    output logic               resp_err,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [W-1:0]       divisor,
    output logic               divisor_valid,
    input  logic [W-1:0]       result,
    input  logic               complete
);

    localparam int CW = $clog2(TIMEOUT);

    ctrl_state_t      state, state_next;
    lane_idx_t        rr_ptr, owner, grant_idx;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] owner_onehot;
    logic [W-1:0]     sel_data;
    logic [CW-1:0]    wait_cnt;
    logic             timed_out;
    logic             owner_ready;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sel_data = req_data[i*W +: W];
        end
    end

    assign owner_onehot = N_REQ'(1) << owner;
    assign owner_ready  = |(resp_ready & owner_onehot);
    assign timed_out    = (wait_cnt == CW'(TIMEOUT - 1));

    assign req_ready     = (state == IDLE && !rst) ? grant : '0;
    assign divisor_valid = (state == ISSUE);
    assign resp_valid    = (state == RESP) ? owner_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (complete || timed_out) state_next = RESP;
            RESP:    if (owner_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            divisor   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner   <= grant_idx;
                        divisor <= sel_data;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    // complete takes precedence over a coincident timeout
                    if (complete) begin
                        resp_data <= result;
                        resp_err  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data <= W'(FP16_QNAN);
                        resp_err  <= 1'b1;
                    end
                    if (!timed_out) wait_cnt <= wait_cnt + CW'(1);
                end
                RESP: begin
                    if (owner_ready)
                        rr_ptr <= (owner == lane_idx_t'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_recip_share_ctrl.sv
// tb/tb_recip_share_ctrl.sv - randomized self-checking bench for recip_share_ctrl
module tb_recip_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_data;
    logic [W-1:0]   resp_data, divisor, result;
    logic           resp_err, divisor_valid, complete;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_ptr   = 0;

    always #5 clk = ~clk;

    recip_share_ctrl #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .resp_ready    (resp_ready),
        .divisor       (divisor),
        .divisor_valid (divisor_valid),
        .result        (result),
        .complete      (complete)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lowest priority goes to the lane served last: search upward from rr_ptr
    function automatic int model_grant(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[(rr_ptr + i) % N]) return (rr_ptr + i) % N;
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " req_ready"}, req_ready, 0);
        check_eq({tag, " resp_valid"}, resp_valid, 0);
        check_eq({tag, " resp_data"}, resp_data, 0);
        check_eq({tag, " resp_err"}, resp_err, 0);
        check_eq({tag, " divisor"}, divisor, 0);
        check_eq({tag, " divisor_valid"}, divisor_valid, 0);
    endtask

    // lat: cycles from the issue pulse to complete; outside 1..TO means the unit hangs
    task automatic run_op(input logic [N-1:0] lanes, input int lat, input int hold,
                          input bit late, input logic [W-1:0] res);
        logic [W-1:0] d [N];
        int g, resp_at;
        bit ok_cmp;
        for (int i = 0; i < N; i++) begin
            d[i] = W'($urandom);
            req_data[i*W +: W] = d[i];
        end
        req_valid  = lanes;
        resp_ready = '0;
        complete   = 1'b0;
        #1;
        g = model_grant(lanes);
        check_eq("req_ready grant", req_ready, N'(1) << g);
        tick();
        req_valid = '0;
        #1;
        check_eq("divisor_valid issue", divisor_valid, 1);
        check_eq("divisor", divisor, d[g]);
        check_eq("req_ready busy", req_ready, 0);
        ok_cmp  = (lat >= 1 && lat <= TO);
        resp_at = ok_cmp ? lat + 2 : TO + 2;
        for (int k = 2; k < resp_at; k++) begin
            tick();
            complete = ok_cmp && (k == lat + 1);
            result   = complete ? res : W'($urandom);
            #1;
            check_eq("no early resp", resp_valid, 0);
            check_eq("single issue pulse", divisor_valid, 0);
        end
        for (int h = 0; h <= hold; h++) begin
            tick();
            complete   = late && ($urandom_range(0, 1) == 1);
            result     = W'($urandom);
            resp_ready = N'($urandom);
            resp_ready[g] = (h == hold);
            #1;
            check_eq("resp_valid", resp_valid, N'(1) << g);
            check_eq("resp_data", resp_data, ok_cmp ? res : 16'h7E00);
            check_eq("resp_err", resp_err, !ok_cmp);
            check_eq("req_ready in resp", req_ready, 0);
        end
        tick();
        complete   = 1'b0;
        resp_ready = '0;
        rr_ptr     = (g + 1) % N;
    endtask

    task automatic idle(input int n, input bit stray);
        for (int c = 0; c < n; c++) begin
            req_valid = '0;
            complete  = stray;
            result    = W'($urandom);
            #1;
            check_eq("idle no resp", resp_valid, 0);
            check_eq("idle no issue", divisor_valid, 0);
            tick();
        end
        complete = 1'b0;
    endtask

    initial begin
        int r, lat;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = '0;
        result     = '0;
        complete   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_op(4'b0100, 12, 0, 1'b0, 16'h3800);
        run_op(4'b0010, 5, 10, 1'b0, W'($urandom));
        run_op(4'b0001, -1, 2, 1'b1, W'($urandom));
        run_op(4'b0001, 7, 0, 1'b0, W'($urandom));
        run_op(4'b1000, TO, 0, 1'b0, W'($urandom));
        run_op(4'b1001, TO + 1, 0, 1'b1, W'($urandom));
        idle(3, 1'b1);

        // Abort an operation mid-wait after moving the pointer away from lane 0
        run_op(4'b0100, 3, 0, 1'b0, W'($urandom));
        req_valid = 4'b1000;
        req_data  = {$urandom, $urandom};
        #1;
        check_eq("pre-abort grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid-op reset");
        rst    = 1'b0;
        rr_ptr = 0;
        tick();
        idle(4, 1'b0);

        for (int i = 0; i < 5; i++)
            run_op(4'hF, $urandom_range(1, 20), 0, 1'b0, W'($urandom));

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      lat = -1;
            else if (r == 1) lat = TO;
            else if (r == 2) lat = TO + 1;
            else             lat = $urandom_range(1, 30);
            run_op(N'($urandom_range(1, 15)), lat, $urandom_range(0, 10),
                   $urandom_range(0, 1) == 1, W'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
